// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if -- EX-stage hookup for the sequential M-extension unit.
// Carries the op request (start/func3/op_a/op_b), the redirect kill (flush)
// and the unit's replies (stall/done/result).
//   master : the pipeline side, drives the request and flush
//   slave  : the multiply/divide unit
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, func3, op_a, op_b, flush,
                  input  stall, done, result);
  modport slave  (input  start, func3, op_a, op_b, flush,
                  output stall, done, result);
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq -- iterative RV32M multiply/divide unit for the EX stage.
// One radix-2 step per clock: shift-add multiply on operand magnitudes,
// restoring shift-subtract divide. Signs are fixed once at the end.
// Divide-by-zero and signed overflow complete on the accept edge.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ex_muldiv_if.slave
//          start/func3/op_a/op_b : op request, latched on accept
//          flush                 : kill the EX instruction
//          stall                 : hold IF/ID/EX while an op is pending
//          done                  : one-cycle result-valid pulse
//          result                : last completed result, held
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          func3_q, func3_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
  logic                div_zero, div_ovf, special;
  logic signed [XLEN-1:0] sa, sb;
  logic [XLEN-1:0]     mag_a, mag_b, special_res;

  logic [XLEN:0]       mul_sum;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   acc_step;

  // Final sign fix and result-half selection from the iterated magnitudes.
  // Multiply: acc holds the 64-bit product. Divide: acc = {rem, quot}.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2*XLEN-1:0] acc,
    input logic [2:0]        f3,
    input logic              neg
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!f3[2]) begin
      fix_result = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      fix_result = f3[1] ? rem : quo;
    end
  endfunction

  // Accept-time decode of the incoming op
  always_comb begin
    is_div   = bus.func3[2];
    // signed a: MULH, MULHSU, DIV, REM; signed b: MULH, DIV, REM
    a_signed = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
               (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
    b_signed = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) ||
               (bus.func3 == 3'b110);
    sa       = signed'(bus.op_a);
    sb       = signed'(bus.op_b);
    a_neg    = a_signed && (sa < 0);
    b_neg    = b_signed && (sb < 0);
    mag_a    = a_neg ? $unsigned(-sa) : bus.op_a;
    mag_b    = b_neg ? $unsigned(-sb) : bus.op_b;
    // remainder follows the dividend; product and quotient follow a^b
    neg_in   = (is_div && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (bus.op_b == '0);
    div_ovf  = is_div && !bus.func3[0] &&
               (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.func3[1] ? bus.op_a : '1;
    else          special_res = bus.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept   = (state_q == S_IDLE) && bus.start && !bus.flush;
  end

  // One iteration step on the latched operands
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // partial remainder after shifting in the next dividend bit is acc[63:31]
    div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
    div_rem  = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
    if (func3_q[2]) begin
      if (div_ge) acc_step = {div_rem, acc_q[XLEN-2:0], 1'b1};
      else        acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // FSM: state register plus all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_FIN : S_CALC;
      S_CALC: begin
        if (bus.flush)               state_d = S_IDLE;
        else if (cnt_q == 5'd31)     state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      cnt_d   = '0;
      func3_d = bus.func3;
      neg_d   = neg_in;
      // multiply adds |a| under the bits of |b|; divide subtracts |b|
      opnd_d  = is_div ? mag_b : mag_a;
      acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      if (special) result_d = special_res;
    end else if ((state_q == S_CALC) && !bus.flush) begin
      cnt_d = cnt_q + 5'd1;
      acc_d = acc_step;
      if (cnt_q == 5'd31) result_d = fix_result(acc_step, func3_q, neg_q);
    end
  end

  // FSM: outputs
  always_comb begin
    bus.stall  = !rst && (accept || (state_q == S_CALC));
    bus.done   = (state_q == S_FIN) && !bus.flush;
    bus.result = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq -- directed and random checks of ex_muldiv_seq against
// an arithmetic reference of the RV32M rules.
module tb_ex_muldiv_seq;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [31:0] last_res;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then follow it to done and check timing, stall and value.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit hold, input string tag);
    logic [31:0] exp;
    int lat, k, stall_cnt;
    bit seen;
    exp = ref_model(f3, a, b);
    lat = is_special(f3, a, b) ? 0 : 32;
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = f3; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
    #1 chk({tag, "_stall_req"}, 64'(bus.stall), 64'd1);
    @(posedge clk);
    @(negedge clk);
    // operands are latched: scramble the inputs from here on
    bus.func3 = 3'($urandom_range(0, 7));
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    if (!hold) bus.start = 1'b0;
    k = 0; seen = 1'b0; stall_cnt = 0;
    while (!seen && k <= 40) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.stall) stall_cnt++;
        k++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_latency"}, 64'(k), 64'(lat));
      chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
      chk({tag, "_stall_fin"}, 64'(bus.stall), 64'd0);
      chk({tag, "_result"}, 64'(bus.result), 64'(exp));
      bus.start = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_result_hold"}, 64'(bus.result), 64'(exp));
      last_res = exp;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    compared   = 0;
    mismatched = 0;
    last_res   = 32'd0;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.func3  = 3'd0;
    bus.op_a   = 32'd5;
    bus.op_b   = 32'd6;
    bus.flush  = 1'b0;

    // reset state, with start held high
    #2;
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    chk("rst_stall_clk", 64'(bus.stall), 64'd0);
    bus.start = 1'b0;
    rst = 1'b0;

    // directed values
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, "mul_7_m3");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhu_ff");
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulh_ff");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mulhsu_ff");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, "div_m7_2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, "rem_m7_2");
    run_op(3'd5, 32'hFFFFFFF9, 32'd2, 1'b0, "divu_m7_2");
    run_op(3'd7, 32'd100, 32'd7, 1'b1, "remu_hold_start");

    // special cases
    run_op(3'd5, 32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 1'b0, "remu_by0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, "rem_ovf");
    run_op(3'd6, 32'h12345678, 32'd0, 1'b0, "rem_by0");

    // flush beats start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'd0;
    #1 chk("flush_pri_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1 chk("flush_pri_not_acc", 64'(bus.stall), 64'd0);

    // flush at CALC iteration 10
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_pre_stall", 64'(bus.stall), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_stall", 64'(bus.stall), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    chk("flush_result", 64'(bus.result), 64'(last_res));
    run_op(3'd4, 32'd1000, 32'hFFFFFFF9, 1'b0, "after_flush_div");

    // reset pulse at CALC iteration 20
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'd3; bus.op_a = 32'hDEADBEEF; bus.op_b = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 1'b0, "after_rst_mul");

    // random ops
    for (int i = 0; i < 16; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_op(rf3, ra, rb, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width; only the value 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: EX holds an M-extension op (the ALU's mop_en).
REQ-005 SHALL have port func3, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op_a, input, 32 bits: forwarded rs1 value (post-forwarding op_A).
REQ-007 SHALL have port op_b, input, 32 bits: forwarded rs2 value (post-forwarding op_B).
REQ-008 SHALL have port flush, input, 1 bit: branch/redirect kill of the EX instruction.
REQ-009 SHALL have port stall, output, 1 bit: freeze IF/ID/EX pipeline registers.
REQ-010 SHALL have port done, output, 1 bit: result valid this cycle; one-cycle pulse.
REQ-011 SHALL have port result, output, 32 bits: final value, held until the next done.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIN.
REQ-013 SHALL accept an op only when state is IDLE and start=1; the accept edge latches func3, op_a and op_b.
REQ-014 SHALL, on accept, go to CALC with iteration counter = 0, unless a special case from REQ-019 or REQ-020 applies, in which case it SHALL go directly to FIN.
REQ-015 SHALL perform one radix-2 iteration per edge in CALC:
  - shift-add for multiply, forming a 64-bit magnitude product;
  - restoring shift-subtract for divide, forming a 32-bit quotient and remainder.
REQ-016 SHALL increment the counter on each CALC edge; the 32nd iteration edge SHALL move the FSM to FIN.
REQ-017 SHALL drive done=1 for exactly the one cycle spent in FIN, with result valid; the next edge SHALL return the FSM to IDLE.
REQ-018 SHALL apply these sign rules:
  - signed operands are converted to magnitudes before iterating;
  - final sign fix: product negated if sign(a) XOR sign(b); quotient likewise; remainder takes the sign of the dividend;
  - MULHSU treats op_a as signed and op_b as unsigned;
  - MUL returns product bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
REQ-019 SHALL handle divide by zero (op_b=0):
  - DIV/DIVU return 0xFFFFFFFF;
  - REM/REMU return op_a;
  - done comes one cycle after accept.
REQ-020 SHALL handle signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF):
  - DIV returns 0x80000000;
  - REM returns 0;
  - done comes one cycle after accept.
REQ-021 SHALL give done 32 cycles after the accept edge in the normal case, and 1 cycle after it in the special cases.
REQ-022 SHALL compute stall = (IDLE and start and not flush) or CALC; stall SHALL be 0 in FIN so the pipeline advances and captures result.
REQ-023 SHALL ignore start while in CALC or FIN; no new operation is queued.
REQ-024 SHALL, when flush=1 in CALC or FIN, move the FSM to IDLE on the next edge: done is not asserted, result is unchanged, and stall drops at that edge.
REQ-025 SHALL give flush priority over start when both are 1 in IDLE: the op is not accepted.
REQ-026 SHALL update result only on entry to FIN.

Reset
REQ-027 SHALL, while rst=1, immediately force state=IDLE, counter=0, done=0, result=0 and internal operands=0, regardless of the clock.
REQ-028 SHALL, on rst assertion mid-CALC, abandon the op (no done); start may be accepted on the first edge after rst deasserts.
REQ-029 SHALL hold stall at 0 during reset.

Verification
REQ-030 SHALL cover MUL: op_a=7, op_b=0xFFFFFFFD -> stall high for 32 cycles, done at accept+32, result=0xFFFFFFEB.
REQ-031 SHALL cover MULH/MULHU: op_a=op_b=0xFFFFFFFF -> MULHU gives 0xFFFFFFFE; MULH gives 0x00000000; MULHSU gives 0xFFFFFFFF.
REQ-032 SHALL cover DIV/REM: op_a=0xFFFFFFF9 (-7), op_b=2 -> DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU gives 0x7FFFFFFC.
REQ-033 SHALL cover special cases:
  - DIVU 5/0 -> done at accept+1, result 0xFFFFFFFF; REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 SHALL cover flush: flush at CALC iteration 10 -> no done, stall=0 next cycle, result unchanged; a start two cycles later is accepted and completes correctly.
REQ-035 SHALL cover reset: rst pulse at CALC iteration 20 -> done=0, result=0, stall=0 at once; a subsequent MUL 3*4 gives 12 at accept+32.
